// File: rtl/jtkonami_main_dec.sv
// Main CPU address decoder for Konami boards: chip selects, banked ROM address,
// input/DIP read mux, and the write side (bank, coin counters, sound latch/IRQ, watchdog).
module jtkonami_main_dec #(
   parameter int unsigned BANKW     = 2,
   parameter int unsigned ROM_AW    = 17,
   parameter int unsigned BANK_BASE = 32'h10000,
   parameter int unsigned IRQ_LEN   = 8,
   parameter int unsigned WDOG_LEN  = 4096
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_cen_i,
   input  logic [15:0]       a_i,
   input  logic              vma_i,
   input  logic              rnw_i,
   input  logic [7:0]        cpu_dout_i,
   output logic [7:0]        cpu_din_o,
   output logic [ROM_AW-1:0] rom_addr_o,
   output logic              rom_cs_o,
   input  logic [7:0]        rom_data_i,
   output logic              ram_cs_o,
   input  logic [7:0]        ram_dout_i,
   output logic              gfx_cs_o,
   input  logic [7:0]        gfx_dout_i,
   input  logic              pal_cs_i,
   input  logic [7:0]        pal_dout_i,
   input  logic [1:0]        start_button_i,
   input  logic [1:0]        coin_input_i,
   input  logic [6:0]        joystick1_i,
   input  logic [6:0]        joystick2_i,
   input  logic              service_i,
   input  logic [7:0]        dipsw_a_i,
   input  logic [7:0]        dipsw_b_i,
   input  logic [3:0]        dipsw_c_i,
   output logic [1:0]        coin_cnt_o,
   output logic [7:0]        snd_latch_o,
   output logic              snd_irq_o,
   input  logic              snd_ack_i,
   output logic              wdog_rst_o
);

   localparam int unsigned OFFW    = BANKW + 13;
   localparam int unsigned WDW     = (WDOG_LEN > 2) ? $clog2(WDOG_LEN) : 1;
   localparam int unsigned WD_LAST = (WDOG_LEN == 0) ? 0 : WDOG_LEN - 1;

   if (BANKW < 1 || BANKW > 4) begin : g_bad_bankw
      $error("BANKW must be in 1..4");
   end
   if (ROM_AW < 16 || ROM_AW < OFFW) begin : g_bad_rom_aw
      $error("ROM_AW must be >= 16 and >= BANKW+13");
   end
   if (IRQ_LEN < 1 || IRQ_LEN > 255) begin : g_bad_irq_len
      $error("IRQ_LEN must be in 1..255");
   end

   logic [BANKW-1:0] bank_q, bank_d;
   logic [1:0]       coin_q, coin_d;
   logic [7:0]       latch_q, latch_d;
   logic             pend_q, pend_d;
   logic             irq_q, irq_d;
   logic [7:0]       irq_cnt_q, irq_cnt_d;
   logic [WDW-1:0]   wd_cnt_q, wd_cnt_d;
   logic             wdog_q, wdog_d;
   logic [7:0]       port_in_q, port_in_d;

   logic             io_cs, io_sel, wr_en;
   logic [2:0]       fn;
   logic [OFFW-1:0]  bank_off;
   logic [31:0]      banked;

   assign fn       = a_i[4:2];
   assign io_cs    = vma_i && (a_i[15:10] == 6'd1);
   assign io_sel   = io_cs && (a_i[4:3] == 2'b00);
   assign wr_en    = cpu_cen_i && io_cs && !rnw_i;
   assign rom_cs_o = vma_i && rnw_i && (a_i[15:14] != 2'b00);
   assign ram_cs_o = (a_i[15:12] == 4'd3);
   assign gfx_cs_o = (a_i[15:12] < 4'd3) && !io_cs;

   // Banked window 0x4000-0x5FFF lands at BANK_BASE + bank*8K; above it the ROM is mapped flat
   assign bank_off   = {bank_q, a_i[12:0]};
   assign banked     = BANK_BASE + 32'(bank_off);
   assign rom_addr_o = (a_i[15:13] == 3'b010) ? ROM_AW'(banked) : ROM_AW'(a_i);

   function automatic logic [7:0] joy_byte(input logic [6:0] j);
      return {2'b11, j[5:4], j[2], j[3], j[0], j[1]};
   endfunction

   always_comb begin
      port_in_d = 8'hFF;
      if (io_cs && fn == 3'd0) begin
         case (a_i[1:0])
            2'd0:    port_in_d = {3'b111, start_button_i, service_i, coin_input_i};
            2'd1:    port_in_d = joy_byte(joystick1_i);
            2'd2:    port_in_d = joy_byte(joystick2_i);
            default: port_in_d = {pend_q, 2'b11, dipsw_c_i, joystick1_i[6]};
         endcase
      end else if (io_cs && fn == 3'd1) begin
         port_in_d = a_i[0] ? dipsw_a_i : dipsw_b_i;
      end
   end

   always_comb begin
      if (rom_cs_o)      cpu_din_o = rom_data_i;
      else if (ram_cs_o) cpu_din_o = ram_dout_i;
      else if (pal_cs_i) cpu_din_o = pal_dout_i;
      else if (io_sel)   cpu_din_o = port_in_q;
      else if (gfx_cs_o) cpu_din_o = gfx_dout_i;
      else               cpu_din_o = 8'hFF;
   end

   // Write side: later assignments take priority (trigger beats ack, latch write beats ack)
   always_comb begin
      bank_d    = bank_q;
      coin_d    = coin_q;
      latch_d   = latch_q;
      pend_d    = pend_q;
      irq_d     = irq_q;
      irq_cnt_d = irq_cnt_q;
      wd_cnt_d  = wd_cnt_q;
      wdog_d    = 1'b0;

      if (snd_ack_i) begin
         pend_d    = 1'b0;
         irq_d     = 1'b0;
         irq_cnt_d = 8'd0;
      end else if (cpu_cen_i && irq_cnt_q != 8'd0) begin
         irq_cnt_d = irq_cnt_q - 8'd1;
         if (irq_cnt_q == 8'd1) irq_d = 1'b0;
      end

      if (wr_en) begin
         case (fn)
            3'd2: coin_d = cpu_dout_i[1:0];
            3'd4: bank_d = cpu_dout_i[BANKW-1:0];
            3'd5: begin
               latch_d = cpu_dout_i;
               pend_d  = 1'b1;
            end
            3'd6: begin
               irq_d     = 1'b1;
               irq_cnt_d = 8'(IRQ_LEN);
            end
            default: ;
         endcase
      end

      if (WDOG_LEN != 0 && cpu_cen_i) begin
         if (wr_en && fn == 3'd7) begin
            wd_cnt_d = '0;
         end else if (wd_cnt_q == WDW'(WD_LAST)) begin
            wd_cnt_d = '0;
            wdog_d   = 1'b1;
         end else begin
            wd_cnt_d = wd_cnt_q + WDW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bank_q    <= '0;
         coin_q    <= 2'd0;
         latch_q   <= 8'd0;
         pend_q    <= 1'b0;
         irq_q     <= 1'b0;
         irq_cnt_q <= 8'd0;
         wd_cnt_q  <= '0;
         wdog_q    <= 1'b0;
         port_in_q <= 8'hFF;
      end else begin
         bank_q    <= bank_d;
         coin_q    <= coin_d;
         latch_q   <= latch_d;
         pend_q    <= pend_d;
         irq_q     <= irq_d;
         irq_cnt_q <= irq_cnt_d;
         wd_cnt_q  <= wd_cnt_d;
         wdog_q    <= wdog_d;
         port_in_q <= port_in_d;
      end
   end

   assign coin_cnt_o  = coin_q;
   assign snd_latch_o = latch_q;
   assign snd_irq_o   = irq_q;
   assign wdog_rst_o  = wdog_q;

endmodule

// File: tb/tb_jtkonami_main_dec.sv
// Bench for jtkonami_main_dec: tick-count based reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_jtkonami_main_dec;
   localparam int unsigned BANKW     = 2;
   localparam int unsigned ROM_AW    = 17;
   localparam int unsigned BANK_BASE = 32'h10000;
   localparam int unsigned IRQ_LEN   = 8;
   localparam int unsigned WDOG_LEN  = 4096;

   logic              clk = 1'b0;
   logic              rst, cpu_cen, vma, rnw, pal_cs, service, snd_ack;
   logic [15:0]       a;
   logic [7:0]        cpu_dout, rom_data, ram_dout, gfx_dout, pal_dout, dipsw_a, dipsw_b;
   logic [1:0]        start_button, coin_input;
   logic [6:0]        joystick1, joystick2;
   logic [3:0]        dipsw_c;
   logic [7:0]        cpu_din, snd_latch;
   logic [ROM_AW-1:0] rom_addr;
   logic              rom_cs, ram_cs, gfx_cs, snd_irq, wdog_rst;
   logic [1:0]        coin_cnt;

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // Reference state, advanced once per clk edge
   logic [BANKW-1:0] m_bank;
   logic [1:0]       m_coin;
   logic [7:0]       m_latch, m_port;
   logic             m_pend, m_irq, m_wd;
   int               m_ticks, m_irq_start, m_wd_start;

   always #5 clk = ~clk;

   jtkonami_main_dec #(
      .BANKW(BANKW), .ROM_AW(ROM_AW), .BANK_BASE(BANK_BASE),
      .IRQ_LEN(IRQ_LEN), .WDOG_LEN(WDOG_LEN)
   ) dut (
      .clk(clk), .rst(rst), .cpu_cen_i(cpu_cen),
      .a_i(a), .vma_i(vma), .rnw_i(rnw), .cpu_dout_i(cpu_dout), .cpu_din_o(cpu_din),
      .rom_addr_o(rom_addr), .rom_cs_o(rom_cs), .rom_data_i(rom_data),
      .ram_cs_o(ram_cs), .ram_dout_i(ram_dout), .gfx_cs_o(gfx_cs), .gfx_dout_i(gfx_dout),
      .pal_cs_i(pal_cs), .pal_dout_i(pal_dout),
      .start_button_i(start_button), .coin_input_i(coin_input),
      .joystick1_i(joystick1), .joystick2_i(joystick2), .service_i(service),
      .dipsw_a_i(dipsw_a), .dipsw_b_i(dipsw_b), .dipsw_c_i(dipsw_c), .coin_cnt_o(coin_cnt),
      .snd_latch_o(snd_latch), .snd_irq_o(snd_irq), .snd_ack_i(snd_ack), .wdog_rst_o(wdog_rst)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] joy(input logic [6:0] j);
      return {2'b11, j[5:4], j[2], j[3], j[0], j[1]};
   endfunction

   function automatic logic is_io();
      return vma && (a[15:10] == 6'd1);
   endfunction

   // Value the input/DIP port should present for the current bus, given pending flag p
   function automatic logic [7:0] port_value(input logic p);
      logic [7:0] v;
      v = 8'hFF;
      if (is_io() && a[4:2] == 3'd0) begin
         case (a[1:0])
            2'd0:    v = {3'b111, start_button, service, coin_input};
            2'd1:    v = joy(joystick1);
            2'd2:    v = joy(joystick2);
            default: v = {p, 2'b11, dipsw_c, joystick1[6]};
         endcase
      end else if (is_io() && a[4:2] == 3'd1) begin
         v = a[0] ? dipsw_a : dipsw_b;
      end
      return v;
   endfunction

   function automatic logic [31:0] exp_rom_addr(input logic [15:0] ad, input logic [BANKW-1:0] bk);
      logic [31:0] v;
      if (ad >= 16'h4000 && ad < 16'h6000)
         v = BANK_BASE + 32'(bk) * 32'd8192 + 32'(ad & 16'h1FFF);
      else
         v = 32'(ad);
      return v & ((32'd1 << ROM_AW) - 32'd1);
   endfunction

   // Reference model: IRQ and watchdog tracked as tick counts since the last event
   initial forever begin
      @(posedge clk);
      begin : upd
         logic       wr;
         logic [2:0] fn;
         fn = a[4:2];
         wr = cpu_cen && is_io() && !rnw;
         m_port = port_value(m_pend);
         if (rst) begin
            m_bank = '0; m_coin = 2'd0; m_latch = 8'd0; m_pend = 1'b0;
            m_irq = 1'b0; m_wd = 1'b0; m_port = 8'hFF;
            m_ticks = 0; m_irq_start = 0; m_wd_start = 0;
         end else begin
            m_wd = 1'b0;
            if (snd_ack) begin
               m_irq  = 1'b0;
               m_pend = 1'b0;
            end
            if (cpu_cen) begin
               m_ticks++;
               if (m_irq && (m_ticks - m_irq_start) >= int'(IRQ_LEN)) m_irq = 1'b0;
            end
            if (wr) begin
               case (fn)
                  3'd2: m_coin = cpu_dout[1:0];
                  3'd4: m_bank = cpu_dout[BANKW-1:0];
                  3'd5: begin m_latch = cpu_dout; m_pend = 1'b1; end
                  3'd6: begin m_irq = 1'b1; m_irq_start = m_ticks; end
                  default: ;
               endcase
            end
            if (cpu_cen && WDOG_LEN != 0) begin
               if (wr && fn == 3'd7) m_wd_start = m_ticks;
               else if (m_ticks - m_wd_start == int'(WDOG_LEN)) begin
                  m_wd = 1'b1;
                  m_wd_start = m_ticks;
               end
            end
         end
      end
   end

   // Every-cycle comparison against the model
   initial forever begin
      @(negedge clk);
      if (chk_en) begin : cmp
         logic       io, e_rom, e_ram, e_gfx;
         logic [7:0] e_din;
         io    = is_io();
         e_rom = vma && rnw && (a[15:14] != 2'b00);
         e_ram = (a[15:12] == 4'd3);
         e_gfx = (a[15:12] < 4'd3) && !io;
         if (e_rom)                              e_din = rom_data;
         else if (e_ram)                         e_din = ram_dout;
         else if (pal_cs)                        e_din = pal_dout;
         else if (io && (a[4:2] <= 3'd1))        e_din = m_port;
         else if (e_gfx)                         e_din = gfx_dout;
         else                                    e_din = 8'hFF;
         check("rom_cs", 32'(rom_cs), 32'(e_rom));
         check("ram_cs", 32'(ram_cs), 32'(e_ram));
         check("gfx_cs", 32'(gfx_cs), 32'(e_gfx));
         check("rom_addr", 32'(rom_addr), exp_rom_addr(a, m_bank));
         check("cpu_din", 32'(cpu_din), 32'(e_din));
         check("coin_cnt", 32'(coin_cnt), 32'(m_coin));
         check("snd_latch", 32'(snd_latch), 32'(m_latch));
         check("snd_irq", 32'(snd_irq), 32'(m_irq));
         check("wdog_rst", 32'(wdog_rst), 32'(m_wd));
      end
   end

   task automatic step(input logic cen);
      cpu_cen = cen;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus();
      vma = 1'b0; rnw = 1'b1; a = 16'hFFFF;
   endtask

   task automatic wr(input logic [15:0] addr, input logic [7:0] d);
      a = addr; vma = 1'b1; rnw = 1'b0; cpu_dout = d;
      step(1'b1);
      idle_bus();
   endtask

   task automatic rd(input logic [15:0] addr);
      a = addr; vma = 1'b1; rnw = 1'b1;
   endtask

   task automatic run_ticks(input int n, output int irq_hi, output int wd_p);
      irq_hi = 0;
      wd_p   = 0;
      for (int i = 0; i < n; i++) begin
         step(1'b0);
         if (wdog_rst) wd_p++;
         if (snd_irq) irq_hi++;
         step(1'b1);
         if (wdog_rst) wd_p++;
      end
   endtask

   initial begin : stim
      int irq_hi, wd_p, wd_sum;
      rst = 1'b1; cpu_cen = 1'b0; snd_ack = 1'b0; cpu_dout = 8'h00;
      rom_data = 8'h11; ram_dout = 8'h22; gfx_dout = 8'h3C; pal_dout = 8'h44; pal_cs = 1'b0;
      start_button = 2'b01; service = 1'b0; coin_input = 2'b10;
      joystick1 = 7'h55; joystick2 = 7'h2A;
      dipsw_a = 8'h5A; dipsw_b = 8'hC3; dipsw_c = 4'hA;
      idle_bus();
      step(1'b0);
      chk_en = 1'b1;
      step(1'b1);
      rst = 1'b0;
      step(1'b0);

      // Reset state
      check("rst_irq", 32'(snd_irq), 32'd0);
      check("rst_latch", 32'(snd_latch), 32'd0);
      check("rst_coin", 32'(coin_cnt), 32'd0);
      check("rst_idle_din", 32'(cpu_din), 32'hFF);

      // Bank switch and ROM addressing
      wr(16'h0410, 8'h03);
      rd(16'h5123); #1;
      check("bank_rom_cs", 32'(rom_cs), 32'd1);
      check("bank_addr", 32'(rom_addr), 32'h17123);
      rd(16'h8000); #1;
      check("flat_addr", 32'(rom_addr), 32'h08000);
      idle_bus();

      // Coin counters
      wr(16'h0408, 8'hFE);
      check("coin_wr", 32'(coin_cnt), 32'd2);

      // Input ports
      rd(16'h0400); step(1'b0); check("in_sys", 32'(cpu_din), 32'hEA);
      rd(16'h0401); step(1'b0); check("in_joy1", 32'(cpu_din), 32'hDA);
      rd(16'h0402); step(1'b0); check("in_joy2", 32'(cpu_din), 32'hE5);
      idle_bus(); step(1'b0);

      // Sound latch and pending flag
      wr(16'h0414, 8'hA5);
      check("latch", 32'(snd_latch), 32'hA5);
      rd(16'h0403); step(1'b0);
      check("pend_set", 32'(cpu_din), 32'hF5);
      snd_ack = 1'b1; step(1'b0); snd_ack = 1'b0;
      step(1'b0);
      check("pend_clr", 32'(cpu_din), 32'h75);
      idle_bus();
      snd_ack = 1'b1; wr(16'h0414, 8'h3C); snd_ack = 1'b0;
      rd(16'h0403); step(1'b0);
      check("pend_ack_same", 32'(cpu_din[7]), 32'd1);
      idle_bus();

      // Sound IRQ timeout
      wr(16'h0418, 8'h00);
      check("irq_set", 32'(snd_irq), 32'd1);
      run_ticks(12, irq_hi, wd_p);
      check("irq_len", 32'(irq_hi), 32'd8);
      check("irq_timeout", 32'(snd_irq), 32'd0);
      wr(16'h0418, 8'h00);
      run_ticks(2, irq_hi, wd_p);
      check("irq_before_ack", 32'(snd_irq), 32'd1);
      snd_ack = 1'b1; step(1'b0); snd_ack = 1'b0;
      check("irq_ack", 32'(snd_irq), 32'd0);
      snd_ack = 1'b1; wr(16'h0418, 8'h00); snd_ack = 1'b0;
      check("irq_trig_beats_ack", 32'(snd_irq), 32'd1);
      run_ticks(10, irq_hi, wd_p);

      // DIP switches and misc reads
      rd(16'h0405); #1;
      check("dip_pre", 32'(cpu_din), 32'hFF);
      step(1'b0);
      check("dip_a", 32'(cpu_din), 32'h5A);
      rd(16'h0404); step(1'b0); check("dip_b", 32'(cpu_din), 32'hC3);
      pal_cs = 1'b1; rd(16'h0405); step(1'b0); check("pal_prio", 32'(cpu_din), 32'h44);
      pal_cs = 1'b0;
      rd(16'h2000); #1;
      check("gfx_cs", 32'(gfx_cs), 32'd1);
      check("gfx_din", 32'(cpu_din), 32'h3C);
      rd(16'h3000); #1; check("ram_din", 32'(cpu_din), 32'h22);
      rd(16'h040C); step(1'b0); check("io_unmapped", 32'(cpu_din), 32'hFF);
      rd(16'h0800); step(1'b0);
      idle_bus(); step(1'b0);

      // Watchdog: one pulse without kicks, none with periodic kicks
      wr(16'h041C, 8'h00);
      run_ticks(4100, irq_hi, wd_p);
      check("wdog_one_pulse", 32'(wd_p), 32'd1);
      wd_sum = 0;
      for (int k = 0; k < 3; k++) begin
         wr(16'h041C, 8'h00);
         run_ticks(3999, irq_hi, wd_p);
         wd_sum += wd_p;
      end
      check("wdog_kicked", 32'(wd_sum), 32'd0);

      // Reset in the middle of an IRQ with bank 3 selected
      wr(16'h0410, 8'h03);
      wr(16'h0418, 8'h00);
      run_ticks(2, irq_hi, wd_p);
      rst = 1'b1; step(1'b1); rst = 1'b0;
      check("rst_mid_irq", 32'(snd_irq), 32'd0);
      check("rst_mid_latch", 32'(snd_latch), 32'd0);
      rd(16'h5000); #1;
      check("rst_bank_addr", 32'(rom_addr), 32'h11000);
      idle_bus();
      run_ticks(4, irq_hi, wd_p);

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
